// File: rtl/ramtest_pkg.sv
// ramtest_pkg: shared FSM states and LFSR constants for the SRAM tester.
package ramtest_pkg;
  typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, ERROR} state_t;
  // Right-shift Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;
endpackage

// File: rtl/ramtest_if.sv
// ramtest_if: SRAM address/strobe bundle; the data bus stays a separate tri-state net.
interface ramtest_if;
  logic [19:0] addr;
  logic [3:0] cs_n;
  logic we_n;
  logic oe_n;
  modport master(output addr, cs_n, we_n, oe_n);
  modport slave(input addr, cs_n, we_n, oe_n);
endinterface

// File: rtl/ramtest_lfsr.sv
// ramtest_lfsr: 32-bit Galois LFSR with synchronous load and step.
module ramtest_lfsr
  import ramtest_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEED;
    else if (load) state <= load_val;
    else if (step) state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
  end
endmodule

// File: rtl/ramtest_main.sv
// ramtest_main: endless write/verify soak test of four SRAM chips with LFSR data.
// Define RAMTEST_ERR_LATCH_EN to halt in ERROR on the first miscompare.
module ramtest_main
  import ramtest_pkg::*;
#(
  parameter int          ADDR_BITS = 20,
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic        clk_fpga,
  input  logic        warmres_n,
  input  logic        clk_24mhz,
  output logic        led_diag,
  inout  wire  [7:0]  d,
  output logic [15:0] a,
  output logic        mema14,
  output logic        mema15,
  output logic        mema16,
  output logic        mema17,
  output logic        mema18,
  output logic        mema21,
  output logic        memwe_n,
  output logic        memoe_n,
  output logic        ram0cs_n,
  output logic        ram1cs_n,
  output logic        ram2cs_n,
  output logic        ram3cs_n,
  input  logic [7:0]  zxa,
  input  logic        zxiorq_n,
  input  logic        zxwr_n
);
  state_t r_state, w_next;
  logic [ADDR_BITS+1:0] r_pos;
  logic [31:0] r_save, w_lfsr;
  logic r_err, r_led;
  logic w_last, w_done, w_miss, w_wr_end, w_active, w_unused;
  logic [19:0] w_sa;
  logic [3:0] w_cs_n;
  assign w_unused = ^{clk_24mhz, zxa, zxiorq_n, zxwr_n};
  assign w_last = &r_pos;
  assign w_done = r_state == WR1 || r_state == RD1;
  assign w_miss = r_state == RD1 && d != w_lfsr[7:0];
  assign w_wr_end = r_state == WR1 && w_last;
  assign w_active = r_state inside {WR0, WR1, RD0, RD1};
  // Verify replays the write sequence, so after it the LFSR sits where the write pass ended
  ramtest_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk_fpga), .rst_n(warmres_n), .load(w_wr_end), .load_val(r_save),
    .step(w_done && !w_wr_end), .state(w_lfsr)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = WR0;
      WR0: w_next = WR1;
      WR1: w_next = w_last ? RD0 : WR0;
      RD0: w_next = RD1;
      RD1: w_next = w_last ? WR0 : RD0;
      default: w_next = r_state;
    endcase
`ifdef RAMTEST_ERR_LATCH_EN
    if (w_miss) w_next = ERROR;
`endif
  end
  always_ff @(posedge clk_fpga) begin
    if (!warmres_n) begin
      r_state <= IDLE;
      r_pos <= '0;
      r_save <= LFSR_SEED;
      r_err <= 1'b0;
      r_led <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done) r_pos <= r_pos + (ADDR_BITS+2)'(1);
      if (r_state == WR0 && r_pos == '0) r_save <= w_lfsr;
      if (w_miss) begin
        r_err <= 1'b1;
        r_led <= 1'b1;
      end else if (r_state == RD1 && w_last && !r_err) r_led <= !r_led;
    end
  end
  assign w_sa = 20'(r_pos[ADDR_BITS-1:0]);
  assign w_cs_n = w_active ? ~(4'b0001 << r_pos[ADDR_BITS+1 -: 2]) : 4'hF;
  assign {ram3cs_n, ram2cs_n, ram1cs_n, ram0cs_n} = w_cs_n;
  assign memwe_n = r_state != WR0;
  assign memoe_n = !(r_state == RD0 || r_state == RD1);
  assign d = (r_state == WR0 || r_state == WR1) ? w_lfsr[7:0] : 8'bz;
  assign a = {2'b00, w_sa[13:0]};
  assign {mema21, mema18, mema17, mema16, mema15, mema14} = w_sa[19:14];
  assign led_diag = r_led;
endmodule

// File: tb/tb_ramtest_main.sv
// tb_ramtest_main: directed checks of ramtest_main with ADDR_BITS=4 against an ideal SRAM model.
module tb_ramtest_main;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wire [7:0] d;
  logic [15:0] a;
  logic m14, m15, m16, m17, m18, m21, we_n, oe_n, c0, c1, c2, c3, led;
  logic fault = 1'b0;
  logic probe = 1'b0;
  logic [7:0] mem [64];
  logic [13:0] wlog [$];
  int n_vec = 0, n_bad = 0, n_strb = 0, n_viol = 0, n_oe = 0, cyc = 0;
  ramtest_if bus();
  assign bus.addr = {m21, m18, m17, m16, m15, m14, a[13:0]};
  assign bus.cs_n = {c3, c2, c1, c0};
  assign bus.we_n = we_n;
  assign bus.oe_n = oe_n;
  logic [1:0] chip;
  logic [5:0] sel;
  assign chip = !bus.cs_n[0] ? 2'd0 : !bus.cs_n[1] ? 2'd1 : !bus.cs_n[2] ? 2'd2 : 2'd3;
  assign sel = {chip, bus.addr[3:0]};
  assign d = probe ? 8'h5A :
             (!bus.oe_n && bus.cs_n != 4'hF) ? mem[sel] ^ {7'b0, fault && sel == 6'h23} : 8'bz;
  ramtest_main #(.ADDR_BITS(4)) dut (
    .clk_fpga(clk), .warmres_n(rst_n), .clk_24mhz(clk), .led_diag(led), .d(d), .a(a),
    .mema14(m14), .mema15(m15), .mema16(m16), .mema17(m17), .mema18(m18), .mema21(m21),
    .memwe_n(we_n), .memoe_n(oe_n),
    .ram0cs_n(c0), .ram1cs_n(c1), .ram2cs_n(c2), .ram3cs_n(c3),
    .zxa(8'h00), .zxiorq_n(1'b1), .zxwr_n(1'b1)
  );
  always @(negedge clk) begin
    if (bus.cs_n != 4'hF) n_strb++;
    if ($countones(~bus.cs_n) > 1 || (!bus.we_n && !bus.oe_n)) n_viol++;
    if (!bus.oe_n) n_oe++;
    if (!bus.we_n && bus.cs_n != 4'hF) begin
      mem[sel] <= d;
      wlog.push_back({sel, d});
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_to(input int e);
    while (cyc < e) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  int s0, low;
  initial begin
    probe = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_cs", bus.cs_n, 4'hF);
    chk("rst_we", we_n, 1'b1);
    chk("rst_oe", oe_n, 1'b1);
    chk("rst_led", led, 1'b0);
    chk("rst_d_released", d, 8'h5A);
    chk("rst_addr", bus.addr, 20'h0);
    probe = 1'b0;
    rst_n = 1'b1;
    run_to(1);
    chk("wr0_cs", bus.cs_n, 4'b1110);
    chk("wr0_we", we_n, 1'b0);
    chk("wr0_oe", oe_n, 1'b1);
    chk("wr0_d", d, 8'h01);
    chk("wr0_addr", bus.addr, 20'h0);
    run_to(2);
    chk("wr1_we", we_n, 1'b1);
    chk("wr1_cs", bus.cs_n, 4'b1110);
    chk("wr1_d", d, 8'h01);
    run_to(256);
    chk("led_before", led, 1'b0);
    chk("writes", wlog.size(), 64);
    chk("data1", wlog[1][7:0], 8'h03);
    chk("data2", wlog[2][7:0], 8'h02);
    chk("data3", wlog[3][7:0], 8'h01);
    chk("data4", wlog[4][7:0], 8'h03);
    chk("data5", wlog[5][7:0], 8'h02);
    chk("seq_c0a15", wlog[15][13:8], 6'h0F);
    chk("seq_c1a0", wlog[16][13:8], 6'h10);
    chk("seq_c3a15", wlog[63][13:8], 6'h3F);
    run_to(257);
    chk("led_pass1", led, 1'b1);
    run_to(300);
    chk("oe_cycles", n_oe, 128);
    run_to(512);
    chk("led_hold", led, 1'b1);
    run_to(513);
    chk("led_pass2", led, 1'b0);
    chk("one_cs_no_we_oe", n_viol, 0);
    chk("pre_abort_we", we_n, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", we_n, 1'b1);
    chk("abort_cs", bus.cs_n, 4'hF);
    fault = 1'b1;
    repeat (9) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to(200);
    chk("err_led_before", led, 1'b0);
    run_to(201);
    chk("err_led", led, 1'b1);
    fault = 1'b0;
    s0 = n_strb;
`ifdef RAMTEST_ERR_LATCH_EN
    chk("err_cs", bus.cs_n, 4'hF);
    chk("err_we", we_n, 1'b1);
    chk("err_oe", oe_n, 1'b1);
`endif
    low = 0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (!led) low++;
    end
    chk("err_led_steady", low, 0);
`ifdef RAMTEST_ERR_LATCH_EN
    chk("err_no_strobes", n_strb - s0, 0);
`else
    chk("err_keeps_testing", (n_strb - s0) > 300, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
